// File: rtl/sap_pkg.sv
// Shared SAP-1 control-bit and opcode constants plus the microcode decode.
// Decode is kept as a pure function so the sequencer only adds registers.
package sap_pkg;

  localparam int unsigned UCODE_W = 16;
  localparam int unsigned OPC_LO_W = 4;
  localparam int unsigned STEP_IDX_W = 4;

  localparam logic [UCODE_W-1:0] C_HLT = 16'h8000;
  localparam logic [UCODE_W-1:0] C_MI  = 16'h4000;
  localparam logic [UCODE_W-1:0] C_RI  = 16'h2000;
  localparam logic [UCODE_W-1:0] C_RO  = 16'h1000;
  localparam logic [UCODE_W-1:0] C_IO  = 16'h0800;
  localparam logic [UCODE_W-1:0] C_II  = 16'h0400;
  localparam logic [UCODE_W-1:0] C_AI  = 16'h0200;
  localparam logic [UCODE_W-1:0] C_AO  = 16'h0100;
  localparam logic [UCODE_W-1:0] C_EO  = 16'h0080;
  localparam logic [UCODE_W-1:0] C_SU  = 16'h0040;
  localparam logic [UCODE_W-1:0] C_BI  = 16'h0020;
  localparam logic [UCODE_W-1:0] C_OI  = 16'h0010;
  localparam logic [UCODE_W-1:0] C_CE  = 16'h0008;
  localparam logic [UCODE_W-1:0] C_CO  = 16'h0004;
  localparam logic [UCODE_W-1:0] C_J   = 16'h0002;
  localparam logic [UCODE_W-1:0] C_FI  = 16'h0001;

  typedef enum logic [OPC_LO_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Fetch steps ignore the opcode; execute steps decode only for a valid opcode.
  function automatic logic [UCODE_W-1:0] ucode(
    input logic [OPC_LO_W-1:0]   opc,
    input logic                  opc_ok,
    input logic [STEP_IDX_W-1:0] stp,
    input logic                  carry,
    input logic                  zero
  );
    logic [UCODE_W-1:0] w;
    w = '0;
    if (stp == 4'd0) begin
      w = C_MI | C_CO;
    end else if (stp == 4'd1) begin
      w = C_RO | C_II | C_CE;
    end else if (opc_ok) begin
      case (opc)
        OP_LDA: case (stp)
          4'd2:    w = C_IO | C_MI;
          4'd3:    w = C_RO | C_AI;
          default: w = '0;
        endcase
        OP_ADD: case (stp)
          4'd2:    w = C_IO | C_MI;
          4'd3:    w = C_RO | C_BI;
          4'd4:    w = C_EO | C_AI | C_FI;
          default: w = '0;
        endcase
        OP_SUB: case (stp)
          4'd2:    w = C_IO | C_MI;
          4'd3:    w = C_RO | C_BI;
          4'd4:    w = C_EO | C_AI | C_SU | C_FI;
          default: w = '0;
        endcase
        OP_STA: case (stp)
          4'd2:    w = C_IO | C_MI;
          4'd3:    w = C_AO | C_RI;
          default: w = '0;
        endcase
        OP_LDI:  w = (stp == 4'd2) ? (C_IO | C_AI) : '0;
        OP_JMP:  w = (stp == 4'd2) ? (C_IO | C_J) : '0;
        OP_JC:   w = (stp == 4'd2 && carry) ? (C_IO | C_J) : '0;
        OP_JZ:   w = (stp == 4'd2 && zero) ? (C_IO | C_J) : '0;
        OP_OUT:  w = (stp == 4'd2) ? (C_AO | C_OI) : '0;
        OP_HLT:  w = (stp == 4'd2) ? C_HLT : '0;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Microstep counter: advances when enabled, synchronous clear wins over increment.
module step_counter #(
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [SW-1:0] o_count
);

  logic [SW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= i_clr ? '0 : r_count + SW'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/microcode_sequencer.sv
// SAP-1 style microcode sequencer: registered control word, microstep counter,
// sticky halt and optional early wrap on empty execute steps.
module microcode_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned OPC_W     = 4,
  parameter int unsigned CTRL_W    = 16,
  parameter int unsigned STEPS     = 5,
  parameter int unsigned EARLY_END = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      step_en,
  input  logic [OPC_W-1:0]          instruction,
  input  logic                      carry_flag,
  input  logic                      zero_flag,
  output logic [CTRL_W-1:0]         ctrl_data,
  output logic [$clog2(STEPS)-1:0]  step,
  output logic                      halted,
  output logic                      fetch
);

  localparam int unsigned SW = $clog2(STEPS);

  logic [CTRL_W-1:0]  r_ctrl;
  logic               r_halted;
  logic [SW-1:0]      w_step;
  logic               w_opc_ok;
  logic [UCODE_W-1:0] w_word;
  logic               w_adv;
  logic               w_last;
  logic               w_early;
  logic               w_clr;

  // Opcodes wider than the decode table are valid only with zero upper bits.
  generate
    if (OPC_W > OPC_LO_W) begin : g_wide_opc
      assign w_opc_ok = (instruction[OPC_W-1:OPC_LO_W] == '0);
    end else begin : g_narrow_opc
      assign w_opc_ok = 1'b1;
    end
  endgenerate

  assign w_word  = ucode(instruction[OPC_LO_W-1:0], w_opc_ok, STEP_IDX_W'(w_step),
                         carry_flag, zero_flag);
  assign w_adv   = step_en & ~r_halted;
  assign w_last  = (w_step == SW'(STEPS - 1));
  assign w_early = (EARLY_END != 0) && (w_step >= SW'(2)) && (w_word == '0);
  assign w_clr   = w_last | w_early;

  step_counter #(
    .SW (SW)
  ) u_step_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_adv),
    .i_clr   (w_clr),
    .o_count (w_step)
  );

  // Halt is sticky: once set, w_adv stays low until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_halted <= 1'b0;
    end else if (w_adv) begin
      r_ctrl <= CTRL_W'(w_word);
      if ((w_word & C_HLT) != '0) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign ctrl_data = r_ctrl;
  assign step      = w_step;
  assign halted    = r_halted;
  assign fetch     = (w_step == SW'(0)) || (w_step == SW'(1));

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed self-checking bench for microcode_sequencer with default parameters.
module tb_microcode_sequencer;

  logic        clk;
  logic        rst_n;
  logic        step_en;
  logic [3:0]  instruction;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] ctrl_data;
  logic [2:0]  step;
  logic        halted;
  logic        fetch;

  int n_tests;
  int n_fail;

  microcode_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_en     (step_en),
    .instruction (instruction),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .ctrl_data   (ctrl_data),
    .step        (step),
    .halted      (halted),
    .fetch       (fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then compare control word and step.
  task automatic edge_chk(input string tag, input logic [15:0] ec, input logic [2:0] es);
    @(posedge clk);
    #1;
    check({tag, ".ctrl"}, 32'(ctrl_data), 32'(ec));
    check({tag, ".step"}, 32'(step), 32'(es));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] seq_w [5];
  logic [2:0]  seq_s [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    step_en = 1'b0;
    instruction = 4'h0;
    carry_flag = 1'b0;
    zero_flag = 1'b0;

    #12;
    check("rst.ctrl", 32'(ctrl_data), 32'h0);
    check("rst.step", 32'(step), 32'h0);
    check("rst.halted", 32'(halted), 32'h0);
    check("rst.fetch", 32'(fetch), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // LDA full instruction
    step_en = 1'b1;
    instruction = 4'h1;
    seq_w = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000};
    seq_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int i = 0; i < 5; i++) begin
      edge_chk($sformatf("lda%0d", i), seq_w[i], seq_s[i]);
      if (i == 0) check("lda.fetch1", 32'(fetch), 32'h1);
      if (i == 1) check("lda.fetch2", 32'(fetch), 32'h0);
    end

    // ADD runs the full five steps
    instruction = 4'h2;
    seq_w = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281};
    for (int i = 0; i < 5; i++) edge_chk($sformatf("add%0d", i), seq_w[i], seq_s[i]);

    // JC taken, then early end on empty step 3
    instruction = 4'h7;
    carry_flag = 1'b1;
    edge_chk("jc1.s0", 16'h4004, 3'd1);
    edge_chk("jc1.s1", 16'h1408, 3'd2);
    edge_chk("jc1.s2", 16'h0802, 3'd3);
    edge_chk("jc1.s3", 16'h0000, 3'd0);

    // JC not taken: dead cycle then wrap
    carry_flag = 1'b0;
    edge_chk("jc0.s0", 16'h4004, 3'd1);
    edge_chk("jc0.s1", 16'h1408, 3'd2);
    edge_chk("jc0.s2", 16'h0000, 3'd0);

    // JZ uses zero_flag, not carry
    instruction = 4'h8;
    zero_flag = 1'b1;
    edge_chk("jz1.s0", 16'h4004, 3'd1);
    edge_chk("jz1.s1", 16'h1408, 3'd2);
    edge_chk("jz1.s2", 16'h0802, 3'd3);
    edge_chk("jz1.s3", 16'h0000, 3'd0);
    zero_flag = 1'b0;

    // OUT
    instruction = 4'hE;
    edge_chk("out.s0", 16'h4004, 3'd1);
    edge_chk("out.s1", 16'h1408, 3'd2);
    edge_chk("out.s2", 16'h0110, 3'd3);
    edge_chk("out.s3", 16'h0000, 3'd0);

    // LDA with a 3-cycle stall after the step-2 word
    instruction = 4'h1;
    edge_chk("stl.s0", 16'h4004, 3'd1);
    edge_chk("stl.s1", 16'h1408, 3'd2);
    edge_chk("stl.s2", 16'h4800, 3'd3);
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) edge_chk($sformatf("stl.hold%0d", i), 16'h4800, 3'd3);
    step_en = 1'b1;
    edge_chk("stl.s3", 16'h1200, 3'd4);
    edge_chk("stl.s4", 16'h0000, 3'd0);

    // SUB interrupted by async reset between edges
    instruction = 4'h3;
    edge_chk("sub.s0", 16'h4004, 3'd1);
    edge_chk("sub.s1", 16'h1408, 3'd2);
    edge_chk("sub.s2", 16'h4800, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("sub.arst.ctrl", 32'(ctrl_data), 32'h0);
    check("sub.arst.step", 32'(step), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_chk("sub.r0", 16'h4004, 3'd1);
    edge_chk("sub.r1", 16'h1408, 3'd2);
    edge_chk("sub.r2", 16'h4800, 3'd3);
    edge_chk("sub.r3", 16'h1020, 3'd4);
    edge_chk("sub.r4", 16'h02C1, 3'd0);

    // NOP wraps early after fetch
    instruction = 4'h0;
    edge_chk("nop.s0", 16'h4004, 3'd1);
    edge_chk("nop.s1", 16'h1408, 3'd2);
    edge_chk("nop.s2", 16'h0000, 3'd0);

    // HLT: sticky, frozen regardless of step_en
    instruction = 4'hF;
    edge_chk("hlt.s0", 16'h4004, 3'd1);
    edge_chk("hlt.s1", 16'h1408, 3'd2);
    check("hlt.pre", 32'(halted), 32'h0);
    edge_chk("hlt.s2", 16'h8000, 3'd3);
    check("hlt.set", 32'(halted), 32'h1);
    instruction = 4'h1;
    for (int i = 0; i < 10; i++) begin
      step_en = (i % 3 != 2);
      edge_chk($sformatf("hlt.frz%0d", i), 16'h8000, 3'd3);
      check($sformatf("hlt.stk%0d", i), 32'(halted), 32'h1);
    end
    step_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("hlt.rst.ctrl", 32'(ctrl_data), 32'h0);
    check("hlt.rst.step", 32'(step), 32'h0);
    check("hlt.rst.halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_chk("hlt.after", 16'h4004, 3'd1);

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
